// File: rtl/uart_echo_engine.sv
// UART echo/replay engine: buffers RX words in a FIFO and sends them back on TX, either
// immediately or as a whole line once the terminator word arrives.
module uart_echo_engine #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0] TERM_WORD  = 8'h55,
  parameter int unsigned       CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_activate,
  input  logic              i_mode,
  output logic              o_done,
  input  logic              i_rx_ready,
  input  logic [DATA_W-1:0] i_rx_data,
  input  logic              i_tx_busy,
  output logic              o_tx_start,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_overflow,
  output logic [CNT_W-1:0]  o_tx_count
);

  localparam int unsigned       PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned       OCC_W     = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [OCC_W-1:0]  r_occ;
  logic              r_mode;
  logic              r_term_seen;
  logic              r_overflow;
  logic              r_start_prev;
  logic [DATA_W-1:0] r_tx_data;
  logic [CNT_W-1:0]  r_tx_count;

  logic              w_run_act;
  logic              w_empty;
  logic              w_full;
  logic              w_pop_ok;
  logic              w_pop;
  logic              w_rx_take;
  logic              w_push;
  logic              w_drop;
  logic              w_is_term;
  logic              w_start_session;
  logic              w_flush;
  logic              w_drained;
  logic [DATA_W-1:0] w_head;

  assign w_run_act       = (r_state == StRun) && i_activate;
  assign w_empty         = (r_occ == '0);
  assign w_full          = (r_occ == DEPTH_OCC);
  assign w_pop_ok        = !w_empty && (!r_mode || r_term_seen);
  // r_start_prev is the guard cycle that lets the TX core raise busy after a pulse.
  assign w_pop           = w_run_act && w_pop_ok && !i_tx_busy && !r_start_prev;
  assign w_rx_take       = w_run_act && i_rx_ready && !r_term_seen;
  assign w_push          = w_rx_take && (!w_full || w_pop);
  assign w_drop          = w_rx_take && w_full && !w_pop;
  assign w_is_term       = (i_rx_data == TERM_WORD);
  assign w_start_session = (r_state == StIdle) && i_activate;
  assign w_flush         = w_start_session || ((r_state != StIdle) && !i_activate);
  assign w_head          = r_mem[r_rd_ptr];
  assign w_drained       = r_term_seen && w_empty && !i_tx_busy && !w_pop && !r_start_prev;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (i_activate) w_state_next = StRun;
      StRun: begin
        if (!i_activate) begin
          w_state_next = StIdle;
        end else if (w_drained) begin
          w_state_next = StDone;
        end
      end
      StDone: if (!i_activate) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Outputs; tx_data shows the head during the pulse and the latched copy afterwards.
  always_comb begin
    o_done     = (r_state == StDone);
    o_tx_start = w_pop;
    o_tx_data  = w_pop ? w_head : r_tx_data;
    o_overflow = r_overflow;
    o_tx_count = r_tx_count;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_rx_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop) begin
        r_occ <= r_occ + 1'b1;
      end else if (w_pop && !w_push) begin
        r_occ <= r_occ - 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mode       <= 1'b0;
      r_term_seen  <= 1'b0;
      r_overflow   <= 1'b0;
      r_start_prev <= 1'b0;
      r_tx_data    <= '0;
      r_tx_count   <= '0;
    end else begin
      r_start_prev <= w_pop;
      if (w_start_session) begin
        r_mode      <= i_mode;
        r_term_seen <= 1'b0;
        r_overflow  <= 1'b0;
        r_tx_count  <= '0;
      end else begin
        if (w_pop) begin
          r_tx_data <= w_head;
          if (r_tx_count != '1) r_tx_count <= r_tx_count + 1'b1;
        end
        if (w_drop) r_overflow <= 1'b1;
        // The terminator ends the session even when it could not be buffered.
        if (w_rx_take && w_is_term) r_term_seen <= 1'b1;
      end
    end
  end

endmodule
